// File: rtl/wb_conbus_arb.sv
// ----------------------------------------------------------------------------
// wb_conbus_arb
//   Round-robin arbiter for the Wishbone connection bus, with a watchdog that
//   forces an error termination when the addressed slave never answers.
//
//   State table
//     state | meaning
//     IDLE  | no owner; pick next requester after the last granted master
//     BUSY  | master owns the bus; watchdog counts unterminated STB cycles
//     TOERR | one-cycle forced ERR toward the owner
//     PARK  | timed out; owner keeps grant until it drops CYC, slave ignored
//
//   Ports
//     clk_i, rst_i      clock, synchronous active-high reset
//     m_cyc_i, m_stb_i  per-master CYC / STB
//     s_ack_i/err/rty   termination from the selected slave path
//     gnt_o             one-hot grant (zero when idle)
//     gnt_idx_o         binary index of the owner (holds after release)
//     gnt_valid_o       a master owns the bus
//     to_err_o          one-cycle forced ERR
//     to_busy_o         watchdog timeout in progress
//   All outputs are registered.
// ----------------------------------------------------------------------------
module wb_conbus_arb #(
    parameter int NM      = 8,
    parameter int MW      = 3,
    parameter int TIMEOUT = 256,
    parameter int TW      = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [NM-1:0] m_cyc_i,
    input  logic [NM-1:0] m_stb_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_rty_i,
    output logic [NM-1:0] gnt_o,
    output logic [MW-1:0] gnt_idx_o,
    output logic          gnt_valid_o,
    output logic          to_err_o,
    output logic          to_busy_o
);

    typedef enum logic [1:0] {IDLE, BUSY, TOERR, PARK} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] cnt, cnt_nxt;
    logic [MW-1:0] last_ptr, last_nxt, idx_nxt;
    logic [NM-1:0] gnt_nxt;
    logic          found;
    logic [MW-1:0] winner;
    int            rr_cand;
    logic          own_cyc, own_stb, term;

    assign own_cyc = m_cyc_i[gnt_idx_o];
    assign own_stb = m_stb_i[gnt_idx_o];
    assign term    = s_ack_i | s_err_i | s_rty_i;

    // Scan upward from the master after the last owner, wrapping at NM-1.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        rr_cand = 0;
        for (int i = 1; i <= NM; i++) begin
            rr_cand = (int'(last_ptr) + i) % NM;
            if (!found && m_cyc_i[rr_cand]) begin
                found  = 1'b1;
                winner = MW'(rr_cand);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last_ptr;
        idx_nxt   = gnt_idx_o;
        gnt_nxt   = gnt_o;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                gnt_nxt = '0;
                if (found) begin
                    state_nxt = BUSY;
                    idx_nxt   = winner;
                    last_nxt  = winner;
                    gnt_nxt   = NM'(1) << winner;
                end
            end
            BUSY: begin
                // CYC drop beats the timeout threshold; termination beats it too.
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (own_stb && !term) begin
                    if (cnt == TW'(TIMEOUT - 1))
                        state_nxt = TOERR;
                    else
                        cnt_nxt = cnt + 1'b1;
                end else begin
                    cnt_nxt = '0;
                end
            end
            TOERR, PARK: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = PARK;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            last_ptr    <= MW'(NM - 1);
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
            to_err_o    <= 1'b0;
            to_busy_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last_ptr    <= last_nxt;
            gnt_o       <= gnt_nxt;
            gnt_idx_o   <= idx_nxt;
            gnt_valid_o <= (state_nxt != IDLE);
            to_err_o    <= (state_nxt == TOERR);
            to_busy_o   <= (state_nxt == TOERR) || (state_nxt == PARK);
        end
    end

endmodule

// File: tb/tb_wb_conbus_arb.sv
// ----------------------------------------------------------------------------
// tb_wb_conbus_arb
//   Self-checking bench: directed vector table, hand-written watchdog
//   sequences and randomized traffic, all checked every cycle against a
//   behavioural model (owner / last pointer / unterminated-strobe run length).
// ----------------------------------------------------------------------------
module tb_wb_conbus_arb;
    localparam int NM      = 8;
    localparam int MW      = 3;
    localparam int TIMEOUT = 256;
    localparam int TW      = 9;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [NM-1:0] m_cyc_i = '0;
    logic [NM-1:0] m_stb_i = '0;
    logic          s_ack_i = 1'b0;
    logic          s_err_i = 1'b0;
    logic          s_rty_i = 1'b0;
    logic [NM-1:0] gnt_o;
    logic [MW-1:0] gnt_idx_o;
    logic          gnt_valid_o;
    logic          to_err_o;
    logic          to_busy_o;

    wb_conbus_arb #(.NM(NM), .MW(MW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o), .gnt_valid_o(gnt_valid_o),
        .to_err_o(to_err_o), .to_busy_o(to_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    bit seen_err;

    // behavioural model
    int m_owner = -1;
    int m_last  = NM - 1;
    int m_run   = 0;
    int m_idx   = 0;
    bit m_timed = 0;
    bit m_err   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        if (rst_i) begin
            m_owner = -1; m_last = NM - 1; m_run = 0;
            m_timed = 0;  m_err = 0;       m_idx = 0;
        end else if (m_owner < 0) begin
            m_run = 0; m_timed = 0; m_err = 0;
            for (int k = 1; k <= NM; k++) begin
                int c;
                c = (m_last + k) % NM;
                if (m_cyc_i[c]) begin
                    m_owner = c; m_last = c; m_idx = c;
                    break;
                end
            end
        end else if (!m_cyc_i[m_owner]) begin
            m_owner = -1; m_run = 0; m_timed = 0; m_err = 0;
        end else if (m_timed) begin
            m_err = 0;
        end else if (m_stb_i[m_owner] && !(s_ack_i || s_err_i || s_rty_i)) begin
            if (m_run == TIMEOUT - 1) begin
                m_timed = 1; m_err = 1;
            end else begin
                m_run++;
            end
        end else begin
            m_run = 0;
        end
    endfunction

    function automatic logic [31:0] model_vec();
        logic [NM-1:0] g;
        g = (m_owner >= 0) ? (NM'(1) << m_owner) : '0;
        return {18'd0, g, MW'(m_idx), (m_owner >= 0), m_err, m_timed};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {18'd0, gnt_o, gnt_idx_o, gnt_valid_o, to_err_o, to_busy_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        if (to_err_o) seen_err = 1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic wait_err(output int n);
        n = 0;
        while (!to_err_o && n < 400) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic          rst;
        logic [NM-1:0] cyc;
        logic [NM-1:0] gnt;
        logic [MW-1:0] idx;
        logic          valid;
    } vec_t;

    vec_t tbl[22];

    initial begin
        int n;

        tbl[0]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 8'h05, 8'h00, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 8'h05, 8'h01, 3'd0, 1'b1};
        tbl[5]  = '{1'b0, 8'h05, 8'h01, 3'd0, 1'b1};
        tbl[6]  = '{1'b0, 8'h05, 8'h01, 3'd0, 1'b1};
        tbl[7]  = '{1'b0, 8'h04, 8'h00, 3'd0, 1'b0};
        tbl[8]  = '{1'b0, 8'h05, 8'h04, 3'd2, 1'b1};
        tbl[9]  = '{1'b0, 8'h05, 8'h04, 3'd2, 1'b1};
        tbl[10] = '{1'b0, 8'h05, 8'h04, 3'd2, 1'b1};
        tbl[11] = '{1'b0, 8'h01, 8'h00, 3'd2, 1'b0};
        tbl[12] = '{1'b0, 8'h05, 8'h01, 3'd0, 1'b1};
        tbl[13] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[14] = '{1'b0, 8'h80, 8'h80, 3'd7, 1'b1};
        tbl[15] = '{1'b0, 8'hFF, 8'h80, 3'd7, 1'b1};
        tbl[16] = '{1'b0, 8'h7F, 8'h00, 3'd7, 1'b0};
        tbl[17] = '{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1};
        tbl[18] = '{1'b0, 8'hFE, 8'h00, 3'd0, 1'b0};
        tbl[19] = '{1'b0, 8'hFF, 8'h02, 3'd1, 1'b1};
        tbl[20] = '{1'b0, 8'hFF, 8'h02, 3'd1, 1'b1};
        tbl[21] = '{1'b0, 8'h00, 8'h00, 3'd1, 1'b0};

        for (int i = 0; i < 22; i++) begin
            rst_i   = tbl[i].rst;
            m_cyc_i = tbl[i].cyc;
            tick();
            check($sformatf("vec%0d", i),
                  {gnt_o, gnt_idx_o, gnt_valid_o, to_err_o, to_busy_o},
                  {tbl[i].gnt, tbl[i].idx, tbl[i].valid, 1'b0, 1'b0});
        end

        // ack on the 255th strobe cycle, then an unanswered strobe times out
        rst_i = 1; m_cyc_i = '0; m_stb_i = '0; tick(); rst_i = 0;
        m_cyc_i = 8'h01; tick();
        check("grant_m0", gnt_o, 8'h01);
        seen_err = 0;
        m_stb_i = 8'h01;
        repeat (254) tick();
        s_ack_i = 1; tick(); s_ack_i = 0;
        check("ack255_no_err", seen_err, 0);
        wait_err(n);
        check("timeout_latency", n, 256);
        tick();
        check("park_err_busy", {to_err_o, to_busy_o, gnt_o}, {1'b0, 1'b1, 8'h01});
        s_ack_i = 1; tick(); s_ack_i = 0;
        check("park_ignores_ack", {to_err_o, to_busy_o, gnt_o}, {1'b0, 1'b1, 8'h01});
        m_cyc_i = '0; m_stb_i = '0; tick();
        check("park_release", {gnt_valid_o, to_busy_o, gnt_o}, {1'b0, 1'b0, 8'h00});

        // ack exactly at threshold: termination wins
        m_cyc_i = 8'h01; tick();
        seen_err = 0; m_stb_i = 8'h01;
        repeat (255) tick();
        s_ack_i = 1; tick(); s_ack_i = 0; m_stb_i = '0;
        tick();
        check("ack_at_threshold", {seen_err, to_busy_o}, {1'b0, 1'b0});

        // CYC drop exactly at threshold: drop wins
        m_stb_i = 8'h01;
        repeat (255) tick();
        m_cyc_i = '0; tick(); m_stb_i = '0;
        check("drop_at_threshold", {seen_err, gnt_valid_o, to_busy_o}, {1'b0, 1'b0, 1'b0});

        // reset while parked, pointer back to NM-1
        m_cyc_i = 8'h02; tick();
        check("grant_m1", gnt_idx_o, 3'd1);
        m_stb_i = 8'h02;
        wait_err(n);
        check("timeout_latency2", n, 256);
        tick();
        check("parked", to_busy_o, 1'b1);
        rst_i = 1; tick(); rst_i = 0;
        check("reset_in_park", {gnt_o, gnt_idx_o, gnt_valid_o, to_err_o, to_busy_o}, 14'd0);
        m_cyc_i = 8'h03; m_stb_i = '0; tick();
        check("after_reset_m0", {gnt_o, gnt_idx_o}, {8'h01, 3'd0});
        m_cyc_i = '0; tick();

        // randomized traffic
        for (int blk = 0; blk < 4; blk++) begin
            int flip_p;
            int ack_p;
            flip_p = (blk[0]) ? 600 : 20;
            ack_p  = (blk[1]) ? 400 : 8;
            for (int c = 0; c < 800; c++) begin
                for (int b = 0; b < NM; b++)
                    if ($urandom_range(0, flip_p - 1) == 0) m_cyc_i[b] = ~m_cyc_i[b];
                m_stb_i = m_cyc_i & NM'($urandom);
                s_ack_i = ($urandom_range(0, ack_p - 1) == 0);
                s_err_i = ($urandom_range(0, ack_p * 4 - 1) == 0);
                s_rty_i = ($urandom_range(0, ack_p * 4 - 1) == 0);
                rst_i   = ($urandom_range(0, 999) == 0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
